approx_adder_error_sweeper: RTL and testbench

//  Drive side of an approximate-adder netlist: sweeps every operand pair into the combinational

---
 rtl/approx_eval_pkg.sv | 32 +++
 rtl/approx_err_accum.sv | 118 +++++++++++
 rtl/approx_adder_error_sweeper.sv | 106 ++++++++++
 tb/tb_approx_adder_error_sweeper.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/approx_eval_pkg.sv
// Shared types and width helpers for the approximate-operator sweepers.
// Widths are derived from the operand width so no accumulator can wrap.
package approx_eval_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } sweep_state_e;

  // Exact a+b of two w-bit operands
  function automatic int sum_w(input int w);
    return w + 1;
  endfunction

  // One sweep vector holds both operands
  function automatic int vec_w(input int w);
    return 2 * w;
  endfunction

  // Counts up to 2^(2w) vectors inclusive
  function automatic int cnt_w(input int w);
    return 2 * w + 1;
  endfunction

  // Sum of 2^(2w) errors each below 2^(w+1)
  function automatic int esum_w(input int w);
    return 3 * w + 1;
  endfunction

endpackage

// File: rtl/approx_err_accum.sv
// Stage-1 sample register plus error statistics for one sweep.
// Tracks max, count, sum of |approx-exact| and the first threshold breach.
module approx_err_accum
  import approx_eval_pkg::*;
#(
  parameter int OP_WIDTH = 2,
  parameter int ET       = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          valid,
  input  logic [vec_w(OP_WIDTH)-1:0]    vec,
  input  logic [sum_w(OP_WIDTH)-1:0]    exact,
  input  logic [sum_w(OP_WIDTH)-1:0]    approx,
  output logic [sum_w(OP_WIDTH)-1:0]    max_err,
  output logic [cnt_w(OP_WIDTH)-1:0]    err_count,
  output logic [esum_w(OP_WIDTH)-1:0]   err_sum,
  output logic                          violation,
  output logic [vec_w(OP_WIDTH)-1:0]    first_viol_vec
);

  localparam int VW  = vec_w(OP_WIDTH);
  localparam int SW  = sum_w(OP_WIDTH);
  localparam int CW  = cnt_w(OP_WIDTH);
  localparam int ESW = esum_w(OP_WIDTH);

  logic          s1_valid_q, s1_valid_d;
  logic [VW-1:0] s1_vec_q, s1_vec_d;
  logic [SW-1:0] s1_exact_q, s1_exact_d;
  logic [SW-1:0] s1_approx_q, s1_approx_d;

  logic [SW-1:0]  max_q, max_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [ESW-1:0] sum_q, sum_d;
  logic           viol_q, viol_d;
  logic [VW-1:0]  fvec_q, fvec_d;

  logic [SW-1:0]  err;
  logic [31:0]    err32;

  // Capture the sampled vector and both sums for next-cycle accumulation
  always_comb begin
    s1_valid_d  = valid & ~clear;
    s1_vec_d    = vec;
    s1_exact_d  = exact;
    s1_approx_d = approx;
  end

  // Magnitude of the approximation error; never wraps in SW bits
  always_comb begin
    err = '0;
    if (s1_approx_q >= s1_exact_q) begin
      err = s1_approx_q - s1_exact_q;
    end else begin
      err = s1_exact_q - s1_approx_q;
    end
    err32 = 32'(err);
  end

  // Fold the stage-1 entry into the running statistics
  always_comb begin
    max_d  = max_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    viol_d = viol_q;
    fvec_d = fvec_q;
    if (clear) begin
      max_d  = '0;
      cnt_d  = '0;
      sum_d  = '0;
      viol_d = 1'b0;
      fvec_d = '0;
    end else if (s1_valid_q) begin
      if (err > max_q) begin
        max_d = err;
      end
      cnt_d = cnt_q + CW'(err != '0);
      sum_d = sum_q + ESW'(err);
      if ((err32 > 32'(ET)) && !viol_q) begin
        viol_d = 1'b1;
        fvec_d = s1_vec_q;
      end
    end
  end

  // Stage-1 and statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_vec_q    <= '0;
      s1_exact_q  <= '0;
      s1_approx_q <= '0;
      max_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      viol_q      <= 1'b0;
      fvec_q      <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_vec_q    <= s1_vec_d;
      s1_exact_q  <= s1_exact_d;
      s1_approx_q <= s1_approx_d;
      max_q       <= max_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      viol_q      <= viol_d;
      fvec_q      <= fvec_d;
    end
  end

  assign max_err        = max_q;
  assign err_count      = cnt_q;
  assign err_sum        = sum_q;
  assign violation      = viol_q;
  assign first_viol_vec = fvec_q;

endmodule

// File: rtl/approx_adder_error_sweeper.sv
// Sweeps every operand pair through an approximate adder netlist.
// Owns the sweep FSM and vector counter; statistics live in the accumulator.
module approx_adder_error_sweeper
  import approx_eval_pkg::*;
#(
  parameter int OP_WIDTH = 2,
  parameter int ET       = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [2*OP_WIDTH-1:0]         dut_in,
  input  logic [OP_WIDTH:0]             dut_out,
  output logic [OP_WIDTH:0]             max_err,
  output logic [2*OP_WIDTH:0]           err_count,
  output logic [3*OP_WIDTH:0]           err_sum,
  output logic                          violation,
  output logic [2*OP_WIDTH-1:0]         first_viol_vec
);

  localparam int VW = vec_w(OP_WIDTH);
  localparam int SW = sum_w(OP_WIDTH);

  sweep_state_e  state_q, state_d;
  logic [VW-1:0] vec_q, vec_d;
  logic          clear;
  logic          valid;
  logic [SW-1:0] exact;

  // Next state, vector advance and handshake outputs
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    busy    = 1'b0;
    done    = 1'b0;
    clear   = 1'b0;
    valid   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          clear   = 1'b1;
          vec_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        valid = 1'b1;
        if (vec_q == '1) begin
          state_d = FLUSH;
        end else begin
          vec_d = vec_q + VW'(1);
        end
      end
      FLUSH: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and vector registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
    end
  end

  // Reference sum of the vector currently on the adder inputs
  always_comb begin
    exact = SW'(vec_q[OP_WIDTH-1:0])
          + SW'(vec_q[VW-1:OP_WIDTH]);
  end

  assign dut_in = vec_q;

  approx_err_accum #(
    .OP_WIDTH (OP_WIDTH),
    .ET       (ET)
  ) u_accum (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .valid          (valid),
    .vec            (vec_q),
    .exact          (exact),
    .approx         (dut_out),
    .max_err        (max_err),
    .err_count      (err_count),
    .err_sum        (err_sum),
    .violation      (violation),
    .first_viol_vec (first_viol_vec)
  );

endmodule

// File: tb/tb_approx_adder_error_sweeper.sv
// Bench: three sweepers (ET 7/5/3) share one modelled adder table.
// Expected statistics come from a direct enumeration of all operand pairs.
module tb_approx_adder_error_sweeper;

  logic clk = 1'b0;
  logic rst;
  logic start;

  always #5 clk = ~clk;

  logic       busy [3];
  logic       done [3];
  logic [3:0] dut_in [3];
  logic [2:0] dut_out [3];
  logic [2:0] max_err [3];
  logic [4:0] err_count [3];
  logic [6:0] err_sum [3];
  logic       violation [3];
  logic [3:0] first_viol_vec [3];

  logic [2:0] lut [16];

  int n_checks = 0;
  int n_fail   = 0;
  int ets [3]  = '{7, 5, 3};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int ETV = (g == 0) ? 7 : (g == 1) ? 5 : 3;
    assign dut_out[g] = lut[dut_in[g]];
    approx_adder_error_sweeper #(
      .OP_WIDTH (2),
      .ET       (ETV)
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .busy           (busy[g]),
      .done           (done[g]),
      .dut_in         (dut_in[g]),
      .dut_out        (dut_out[g]),
      .max_err        (max_err[g]),
      .err_count      (err_count[g]),
      .err_sum        (err_sum[g]),
      .violation      (violation[g]),
      .first_viol_vec (first_viol_vec[g])
    );
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("%s.busy%0d", tag, g), 32'(busy[g]), 0);
      check($sformatf("%s.done%0d", tag, g), 32'(done[g]), 0);
      check($sformatf("%s.in%0d", tag, g), 32'(dut_in[g]), 0);
      check($sformatf("%s.max%0d", tag, g), 32'(max_err[g]), 0);
      check($sformatf("%s.cnt%0d", tag, g), 32'(err_count[g]), 0);
      check($sformatf("%s.sum%0d", tag, g), 32'(err_sum[g]), 0);
      check($sformatf("%s.vio%0d", tag, g), 32'(violation[g]), 0);
      check($sformatf("%s.fv%0d", tag, g), 32'(first_viol_vec[g]), 0);
    end
  endtask

  // Enumerate all pairs against the current table
  task automatic check_results(input string tag);
    int mx, cnt, sm, vi, fv, a, b, ex, ap, e;
    for (int g = 0; g < 3; g++) begin
      mx = 0; cnt = 0; sm = 0; vi = 0; fv = 0;
      for (int v = 0; v < 16; v++) begin
        a  = v % 4;
        b  = v / 4;
        ex = a + b;
        ap = int'(lut[v]);
        e  = (ap > ex) ? ap - ex : ex - ap;
        if (e > mx) mx = e;
        if (e != 0) cnt++;
        sm += e;
        if (e > ets[g] && vi == 0) begin
          vi = 1;
          fv = v;
        end
      end
      check($sformatf("%s.max%0d", tag, g), 32'(max_err[g]), mx);
      check($sformatf("%s.cnt%0d", tag, g), 32'(err_count[g]), cnt);
      check($sformatf("%s.sum%0d", tag, g), 32'(err_sum[g]), sm);
      check($sformatf("%s.vio%0d", tag, g), 32'(violation[g]), vi);
      check($sformatf("%s.fv%0d", tag, g), 32'(first_viol_vec[g]), fv);
    end
  endtask

  task automatic run_sweep(input string tag);
    int cyc;
    @(posedge clk);
    #1 start = 1'b1;
    cyc = 0;
    for (int i = 1; i <= 40 && cyc == 0; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        start = 1'b0;
        check({tag, ".busy1"}, 32'(busy[0]), 1);
      end
      if (done[0]) cyc = i;
    end
    check({tag, ".done_cyc"}, cyc, 18);
    check({tag, ".busy_done"}, 32'(busy[0]), 0);
    @(posedge clk);
    #1;
    check({tag, ".done_pulse"}, 32'(done[0]), 0);
    check({tag, ".in_hold"}, 32'(dut_in[0]), 15);
    check_results(tag);
  endtask

  initial begin
    int ndone, first, second;
    rst   = 1'b1;
    start = 1'b0;
    for (int v = 0; v < 16; v++) lut[v] = 3'((v % 4) + (v / 4));
    repeat (2) @(posedge clk);
    #1 check_reset("reset");
    rst = 1'b0;

    run_sweep("exact");

    for (int v = 0; v < 16; v++) lut[v] = 3'd0;
    run_sweep("zero");

    for (int v = 0; v < 16; v++) lut[v] = 3'(((v % 4) + (v / 4)) & 3);
    run_sweep("dropc");

    for (int r = 0; r < 6; r++) begin
      for (int v = 0; v < 16; v++) lut[v] = 3'($urandom_range(0, 7));
      run_sweep($sformatf("rnd%0d", r));
    end

    // Abort mid-sweep with reset
    @(posedge clk);
    #1 start = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 check_reset("midrst");
    rst   = 1'b0;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1 if (done[0]) ndone++;
    end
    check("midrst.nodone", ndone, 0);
    run_sweep("after_rst");

    // Start held for 20 cycles: accepted at cycle 0 and again in IDLE at 19
    for (int v = 0; v < 16; v++) lut[v] = 3'($urandom_range(0, 7));
    @(posedge clk);
    #1 start = 1'b1;
    ndone = 0; first = 0; second = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (i == 20) start = 1'b0;
      if (done[0]) begin
        ndone++;
        if (ndone == 1) first = i;
        if (ndone == 2) second = i;
      end
    end
    check("held.ndone", ndone, 2);
    check("held.first", first, 18);
    check("held.second", second, 37);
    check_results("held");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
